avalon_arbiter2: RTL and testbench
==================================

Name: avalon_arbiter2

Overview:
- Two-master, one-slave arbiter for the core's shared Avalon memory port.
- Master 0 is the instruction bus (IF stage). Master 1 is the data bus (MEM stage). The slave is a single-port memory with fixed read latency.
- Grants one transfer per cycle and stalls the losing master with waitrequest.
- Routes each read response back to the master that issued it, using an in-flight ID pipeline matched to the slave latency.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte_enable width is DATA_W/8.
- READ_LATENCY, 1, fixed slave cycles from accepted read to s_readdata valid; legal range 1..4.
- ROUND_ROBIN, 1, 1 = alternate on contention; 0 = fixed priority to m1 (dbus).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- m0_read / m0_write  in  1  ibus request.
- m0_address  in  ADDR_W  ibus address.
- m0_writedata  in  DATA_W  ibus write data.
- m0_byte_enable  in  DATA_W/8  ibus byte enables.
- m0_waitrequest  out  1  ibus stall.
- m0_readdata  out  DATA_W  ibus read data.
- m0_readdatavalid  out  1  ibus response strobe.
- m1_*  same set as m0_*, for dbus.
- s_read / s_write  out  1  slave request.
- s_address  out  ADDR_W  slave address.
- s_writedata  out  DATA_W  slave write data.
- s_byte_enable  out  DATA_W/8  slave byte enables.
- s_waitrequest  in  1  slave stall.
- s_readdata  in  DATA_W  slave read data, valid READ_LATENCY cycles after acceptance.

Behaviour:
- Request: reqN = mN_read | mN_write. Asserting read and write together on one master is illegal (bench assertion); the arbiter does not need to handle it.
- Grant FSM states: FREE, LOCK0, LOCK1. Reset state is FREE.
  - FREE, single requester: grant it combinationally, same cycle.
  - FREE, both request, ROUND_ROBIN=1: grant the master that is not last_grant.
  - FREE, both request, ROUND_ROBIN=0: grant m1.
  - FREE, granted transfer stalled (s_waitrequest=1): go to LOCKn. Grant stays fixed and slave outputs must stay stable until acceptance, even if the other master raises a request.
  - LOCKn: hold grant n. On acceptance (s_waitrequest=0), return to FREE.
  - A master must not drop its request while locked. Bench asserts this; RTL returns to FREE if it does.
- Slave outputs: s_* mirror the granted master's signals. With no grant, s_read = s_write = 0 and the data/address outputs are don't-care, driven 0.
- Waitrequest:
  - Granted master: mN_waitrequest = s_waitrequest.
  - Non-granted master: mN_waitrequest = 1 whenever it requests.
  - Idle master: mN_waitrequest = 0.
- Acceptance: granted & ~s_waitrequest. An accepted transfer updates last_grant. last_grant resets to m0, so the first contention goes to m1.
- Response pipeline:
  - Shift register of depth READ_LATENCY, one entry per stage {vld, id}.
  - Stage 0 loads {accepted & s_read, grant_id}.
  - At the last stage: mN_readdatavalid = vld & (id==N).
  - Both mN_readdata are driven with s_readdata; data is qualified by readdatavalid.
- Back-to-back reads: one per cycle is sustained when s_waitrequest=0. Responses return in issue order and may interleave masters.
- Writes produce no response entry.
- Reset values (async assert, sync deassert by the environment): FSM = FREE, last_grant = 0, all pipeline vld = 0. Consequently all readdatavalid = 0 and s_read = s_write = 0 (absent requests).
- Reset mid-operation: in-flight reads are discarded, with no readdatavalid after reset. A locked transfer is abandoned.
- Throughput under contention with ROUND_ROBIN=1: each master gets at least one accepted transfer every 2 accepted transfers. No starvation.

Decomposition:
- Shared package core_pkg:
  - arb_state_e enum (FREE, LOCK0, LOCK1).
  - Localparam MAX_READ_LATENCY = 4.
  - Master ID constants IBUS_ID = 0, DBUS_ID = 1.
- Sub-module rsp_id_pipe: parameterized {vld, id} delay line of depth READ_LATENCY, with async reset. Reusable later for the dcache/uncached path.

Test Plan:
- Single ibus read stream, READ_LATENCY=1: m0_read at 0x0, 0x4, 0x8 on consecutive cycles, s_waitrequest=0 -> three s_read pulses; m0_readdatavalid one cycle after each with the matching s_readdata; m1_readdatavalid stays 0.
- Contention, ROUND_ROBIN=1: both masters read continuously for 6 cycles -> grants m1, m0, m1, m0, m1, m0; each master sees exactly 3 readdatavalid pulses, in grant order.
- Lock under stall: m0 granted at 0x100 with s_waitrequest=1 for 3 cycles; m1 raises a write at cycle 1 -> s_address stays 0x100 for all 4 cycles; m1_waitrequest=1 until m0 accepted; m1 write issued the following cycle.
- Fixed priority, ROUND_ROBIN=0: both request for 4 cycles -> m1 granted every cycle; m0_waitrequest=1 throughout; m0 granted the first cycle m1 drops its request.
- READ_LATENCY=3 interleave: reads m0@0x10, m1@0x20, m0@0x30 back-to-back -> readdatavalid to m0, m1, m0 at issue+3, each with data 0x10/0x20/0x30 from the slave model.
- Reset mid-flight: READ_LATENCY=3, two reads accepted, then rst_n low for 1 cycle -> no readdatavalid ever asserted for those reads; FSM in FREE; the first post-reset contention goes to m1.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types and constants for the core's memory-side interconnect.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package core_pkg;

    // Arbiter grant state: free to arbitrate, or held on a slave-stalled transfer.
    typedef enum logic [1:0] {
        FREE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_e;

    // Deepest response pipeline the arbiter supports.
    localparam int MAX_READ_LATENCY = 4;

    // Master identifiers carried alongside in-flight reads.
    localparam logic IBUS_ID = 1'b0;
    localparam logic DBUS_ID = 1'b1;

endpackage

// File: rtl/rsp_id_pipe.sv
// Delay line of {vld, id} pairs used to route fixed-latency read responses.
// Latency: DEPTH cycles from in_* to out_*.
// Backpressure: none; shifts every cycle, matching a fixed-latency slave.
//
// Ports: clk, rst_n (async active-low), in_vld/in_id (stage 0 load),
//        out_vld/out_id (last stage).
module rsp_id_pipe
    import core_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_vld,
    input  logic in_id,
    output logic out_vld,
    output logic out_id
);

    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] id_q;

    // Reset clears every valid bit so nothing issued before reset is delivered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            id_q  <= {DEPTH{IBUS_ID}};
        end else begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                vld_q[i] <= vld_q[i-1];
                id_q[i]  <= id_q[i-1];
            end
            vld_q[0] <= in_vld;
            id_q[0]  <= in_id;
        end
    end

    assign out_vld = vld_q[DEPTH-1];
    assign out_id  = id_q[DEPTH-1];

endmodule

// File: rtl/avalon_arbiter2.sv
// Two-master (ibus m0, dbus m1) to one-slave Avalon arbiter with response routing.
// Latency: request path combinational; read response READ_LATENCY cycles after acceptance.
// Backpressure: loser sees waitrequest=1; winner sees s_waitrequest; stalled grant is locked.
//
// Ports: clk, rst_n (async active-low);
//        m0_*/m1_*: read, write, address, writedata, byte_enable in;
//                   waitrequest, readdata, readdatavalid out;
//        s_*: read, write, address, writedata, byte_enable out;
//             waitrequest, readdata in.
module avalon_arbiter2
    import core_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1,
    parameter int ROUND_ROBIN  = 1
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W-1:0]   m0_writedata,
    input  logic [DATA_W/8-1:0] m0_byte_enable,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,

    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W-1:0]   m1_writedata,
    input  logic [DATA_W/8-1:0] m1_byte_enable,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,

    output logic                s_read,
    output logic                s_write,
    output logic [ADDR_W-1:0]   s_address,
    output logic [DATA_W-1:0]   s_writedata,
    output logic [DATA_W/8-1:0] s_byte_enable,
    input  logic                s_waitrequest,
    input  logic [DATA_W-1:0]   s_readdata
);

    // Legal latency is 1..MAX_READ_LATENCY; out-of-range values are clamped.
    localparam int PIPE_DEPTH = (READ_LATENCY < 1) ? 1 :
                                (READ_LATENCY > MAX_READ_LATENCY) ? MAX_READ_LATENCY :
                                READ_LATENCY;

    arb_state_e state_q, state_d;
    logic       last_grant_q;
    logic       req0, req1;
    logic       gnt_vld, gnt_id;
    logic       accept;
    logic       rsp_vld, rsp_id;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FREE;
            last_grant_q <= IBUS_ID;
        end else begin
            state_q <= state_d;
            if (accept) begin
                last_grant_q <= gnt_id;
            end
        end
    end

    // Grant and next state. A lock only holds while its owner keeps requesting;
    // if the owner drops out we fall back to normal arbitration this cycle.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = IBUS_ID;
        state_d = FREE;
        if (state_q == LOCK0 && req0) begin
            gnt_vld = 1'b1;
            gnt_id  = IBUS_ID;
        end else if (state_q == LOCK1 && req1) begin
            gnt_vld = 1'b1;
            gnt_id  = DBUS_ID;
        end else if (req0 && req1) begin
            gnt_vld = 1'b1;
            gnt_id  = (ROUND_ROBIN != 0) ? ~last_grant_q : DBUS_ID;
        end else if (req0) begin
            gnt_vld = 1'b1;
            gnt_id  = IBUS_ID;
        end else if (req1) begin
            gnt_vld = 1'b1;
            gnt_id  = DBUS_ID;
        end
        if (gnt_vld && s_waitrequest) begin
            state_d = (gnt_id == DBUS_ID) ? LOCK1 : LOCK0;
        end
    end

    // Slave side mirrors the granted master; idle drives zeros.
    always_comb begin
        s_read        = 1'b0;
        s_write       = 1'b0;
        s_address     = '0;
        s_writedata   = '0;
        s_byte_enable = '0;
        if (gnt_vld) begin
            if (gnt_id == DBUS_ID) begin
                s_read        = m1_read;
                s_write       = m1_write;
                s_address     = m1_address;
                s_writedata   = m1_writedata;
                s_byte_enable = m1_byte_enable;
            end else begin
                s_read        = m0_read;
                s_write       = m0_write;
                s_address     = m0_address;
                s_writedata   = m0_writedata;
                s_byte_enable = m0_byte_enable;
            end
        end
    end

    assign accept = gnt_vld & ~s_waitrequest;

    // A requesting master is stalled unless it holds the grant, in which case
    // it sees the slave's own stall.
    assign m0_waitrequest = req0 & (~(gnt_vld & (gnt_id == IBUS_ID)) | s_waitrequest);
    assign m1_waitrequest = req1 & (~(gnt_vld & (gnt_id == DBUS_ID)) | s_waitrequest);

    rsp_id_pipe #(
        .DEPTH (PIPE_DEPTH)
    ) u_rsp_id_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (accept & s_read),
        .in_id   (gnt_id),
        .out_vld (rsp_vld),
        .out_id  (rsp_id)
    );

    assign m0_readdatavalid = rsp_vld & (rsp_id == IBUS_ID);
    assign m1_readdatavalid = rsp_vld & (rsp_id == DBUS_ID);
    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;

endmodule

// File: tb/tb_avalon_arbiter2.sv
// Bench for avalon_arbiter2: u0 is READ_LATENCY=1 fixed priority, u1 is
// READ_LATENCY=3 round robin. Stimulus pushes expected slave transfers and
// read responses into queues; a negedge monitor pops and compares them.
module tb_avalon_arbiter2;

    typedef struct packed {
        logic        wr;
        logic [31:0] adr;
        logic [31:0] wd;
    } sx_t;

    typedef struct packed {
        logic        id;
        logic [31:0] dat;
        logic [31:0] due;
    } rx_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n [2];
    logic        mrd   [2][2];
    logic        mwr   [2][2];
    logic [31:0] madr  [2][2];
    logic [31:0] mwd   [2][2];
    logic [3:0]  mbe   [2][2];
    logic        mwait [2][2];
    logic [31:0] mrdat [2][2];
    logic        mrdv  [2][2];
    logic        srd   [2];
    logic        swrt  [2];
    logic [31:0] sadr  [2];
    logic [31:0] swd   [2];
    logic [3:0]  sbe   [2];
    logic        swait [2];
    logic [31:0] srdat [2];

    avalon_arbiter2 #(.ADDR_W(32), .DATA_W(32), .READ_LATENCY(1), .ROUND_ROBIN(0)) u0 (
        .clk(clk), .rst_n(rst_n[0]),
        .m0_read(mrd[0][0]), .m0_write(mwr[0][0]), .m0_address(madr[0][0]),
        .m0_writedata(mwd[0][0]), .m0_byte_enable(mbe[0][0]), .m0_waitrequest(mwait[0][0]),
        .m0_readdata(mrdat[0][0]), .m0_readdatavalid(mrdv[0][0]),
        .m1_read(mrd[0][1]), .m1_write(mwr[0][1]), .m1_address(madr[0][1]),
        .m1_writedata(mwd[0][1]), .m1_byte_enable(mbe[0][1]), .m1_waitrequest(mwait[0][1]),
        .m1_readdata(mrdat[0][1]), .m1_readdatavalid(mrdv[0][1]),
        .s_read(srd[0]), .s_write(swrt[0]), .s_address(sadr[0]), .s_writedata(swd[0]),
        .s_byte_enable(sbe[0]), .s_waitrequest(swait[0]), .s_readdata(srdat[0])
    );

    avalon_arbiter2 #(.ADDR_W(32), .DATA_W(32), .READ_LATENCY(3), .ROUND_ROBIN(1)) u1 (
        .clk(clk), .rst_n(rst_n[1]),
        .m0_read(mrd[1][0]), .m0_write(mwr[1][0]), .m0_address(madr[1][0]),
        .m0_writedata(mwd[1][0]), .m0_byte_enable(mbe[1][0]), .m0_waitrequest(mwait[1][0]),
        .m0_readdata(mrdat[1][0]), .m0_readdatavalid(mrdv[1][0]),
        .m1_read(mrd[1][1]), .m1_write(mwr[1][1]), .m1_address(madr[1][1]),
        .m1_writedata(mwd[1][1]), .m1_byte_enable(mbe[1][1]), .m1_waitrequest(mwait[1][1]),
        .m1_readdata(mrdat[1][1]), .m1_readdatavalid(mrdv[1][1]),
        .s_read(srd[1]), .s_write(swrt[1]), .s_address(sadr[1]), .s_writedata(swd[1]),
        .s_byte_enable(sbe[1]), .s_waitrequest(swait[1]), .s_readdata(srdat[1])
    );

    // Slave memory model: read data equals the address, returned after the
    // instance's fixed latency.
    logic [31:0] sp0;
    logic [31:0] sp1 [3];
    always @(posedge clk) begin
        sp0    <= sadr[0];
        sp1[0] <= sadr[1];
        sp1[1] <= sp1[0];
        sp1[2] <= sp1[1];
    end
    assign srdat[0] = sp0;
    assign srdat[1] = sp1[2];

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    sx_t sq0[$];
    sx_t sq1[$];
    rx_t rq0[$];
    rx_t rq1[$];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic int sq_size(input int i);
        return (i == 0) ? sq0.size() : sq1.size();
    endfunction
    function automatic int rq_size(input int i);
        return (i == 0) ? rq0.size() : rq1.size();
    endfunction
    function automatic sx_t sq_pop(input int i);
        if (i == 0) return sq0.pop_front();
        return sq1.pop_front();
    endfunction
    function automatic rx_t rq_pop(input int i);
        if (i == 0) return rq0.pop_front();
        return rq1.pop_front();
    endfunction

    task automatic exp_s(input int i, input logic wr, input logic [31:0] a, input logic [31:0] wd);
        sx_t e;
        e = '{wr: wr, adr: a, wd: wd};
        if (i == 0) sq0.push_back(e); else sq1.push_back(e);
    endtask
    task automatic exp_r(input int i, input logic id, input logic [31:0] d, input int unsigned lat);
        rx_t e;
        e = '{id: id, dat: d, due: cyc + lat};
        if (i == 0) rq0.push_back(e); else rq1.push_back(e);
    endtask

    task automatic drv(input int i, input int m, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] wd);
        mrd[i][m]  = rd;
        mwr[i][m]  = wr;
        madr[i][m] = a;
        mwd[i][m]  = wd;
        mbe[i][m]  = 4'hF;
    endtask
    task automatic idle(input int i);
        drv(i, 0, 1'b0, 1'b0, 32'h0, 32'h0);
        drv(i, 1, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic mid();
        @(negedge clk);
    endtask

    // Monitor: every accepted slave transfer and every response strobe must
    // match the head of the corresponding expectation queue.
    sx_t mon_s;
    rx_t mon_r;
    logic mon_id;
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if ((srd[i] || swrt[i]) && !swait[i]) begin
                if (sq_size(i) == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL u%0d_slave_unexpected: got addr 0x%0h, expected no transfer", i, sadr[i]);
                end else begin
                    mon_s = sq_pop(i);
                    chk($sformatf("u%0d_s_write", i), {31'b0, swrt[i]}, {31'b0, mon_s.wr});
                    chk($sformatf("u%0d_s_read", i), {31'b0, srd[i]}, {31'b0, ~mon_s.wr});
                    chk($sformatf("u%0d_s_address", i), sadr[i], mon_s.adr);
                    if (mon_s.wr) chk($sformatf("u%0d_s_writedata", i), swd[i], mon_s.wd);
                end
            end
            if (mrdv[i][0] || mrdv[i][1]) begin
                chk($sformatf("u%0d_rdv_onehot", i), {31'b0, mrdv[i][0] & mrdv[i][1]}, 32'h0);
                mon_id = mrdv[i][1];
                if (rq_size(i) == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL u%0d_rsp_unexpected: got readdatavalid on m%0d, expected none", i, mon_id);
                end else begin
                    mon_r = rq_pop(i);
                    chk($sformatf("u%0d_rsp_id", i), {31'b0, mon_id}, {31'b0, mon_r.id});
                    chk($sformatf("u%0d_rsp_data", i), mrdat[i][mon_id], mon_r.dat);
                    chk($sformatf("u%0d_rsp_cycle", i), cyc, mon_r.due);
                end
            end
        end
    end

    // Masters never present read and write together.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++)
            for (int m = 0; m < 2; m++)
                assert (!(mrd[i][m] && mwr[i][m])) else $error("illegal read+write on u%0d m%0d", i, m);
    end

    int          gs  [6] = '{1, 0, 1, 0, 1, 0};
    logic [31:0] a0s [6] = '{32'h200, 32'h200, 32'h204, 32'h204, 32'h208, 32'h208};
    logic [31:0] a1s [6] = '{32'h300, 32'h304, 32'h304, 32'h308, 32'h308, 32'h30C};

    initial begin
        int g;
        logic [31:0] ga;
        for (int i = 0; i < 2; i++) begin
            idle(i);
            swait[i] = 1'b0;
            rst_n[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;

        // Reset state with no requests.
        mid();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("u%0d_rst_s_read", i), {31'b0, srd[i]}, 32'h0);
            chk($sformatf("u%0d_rst_s_write", i), {31'b0, swrt[i]}, 32'h0);
            chk($sformatf("u%0d_rst_rdv0", i), {31'b0, mrdv[i][0]}, 32'h0);
            chk($sformatf("u%0d_rst_rdv1", i), {31'b0, mrdv[i][1]}, 32'h0);
            chk($sformatf("u%0d_rst_wait0", i), {31'b0, mwait[i][0]}, 32'h0);
            chk($sformatf("u%0d_rst_wait1", i), {31'b0, mwait[i][1]}, 32'h0);
        end
        tick();

        // u0: single ibus read stream at 0x0, 0x4, 0x8.
        for (int k = 0; k < 3; k++) begin
            drv(0, 0, 1'b1, 1'b0, 32'(4 * k), 32'h0);
            exp_s(0, 1'b0, 32'(4 * k), 32'h0);
            exp_r(0, 1'b0, 32'(4 * k), 1);
            mid();
            chk("stream_m0_wait", {31'b0, mwait[0][0]}, 32'h0);
            chk("stream_s_read", {31'b0, srd[0]}, 32'h1);
            tick();
        end
        idle(0);
        repeat (2) tick();

        // u0: m0 read locked under 3 stall cycles while m1 raises a write.
        for (int k = 0; k < 4; k++) begin
            drv(0, 0, 1'b1, 1'b0, 32'h100, 32'h0);
            if (k >= 1) drv(0, 1, 1'b0, 1'b1, 32'h500, 32'hDEAD_0500);
            swait[0] = (k < 3);
            if (k == 3) begin
                exp_s(0, 1'b0, 32'h100, 32'h0);
                exp_r(0, 1'b0, 32'h100, 1);
            end
            mid();
            chk("lock_s_address", sadr[0], 32'h100);
            chk("lock_s_read", {31'b0, srd[0]}, 32'h1);
            chk("lock_m0_wait", {31'b0, mwait[0][0]}, (k < 3) ? 32'h1 : 32'h0);
            if (k >= 1) chk("lock_m1_wait", {31'b0, mwait[0][1]}, 32'h1);
            tick();
        end
        drv(0, 0, 1'b0, 1'b0, 32'h0, 32'h0);
        swait[0] = 1'b0;
        exp_s(0, 1'b1, 32'h500, 32'hDEAD_0500);
        mid();
        chk("lock_m1_write_issued", {31'b0, swrt[0]}, 32'h1);
        chk("lock_m1_wait_release", {31'b0, mwait[0][1]}, 32'h0);
        tick();
        idle(0);
        repeat (2) tick();

        // u0: fixed priority, both read for 4 cycles, then m1 drops.
        for (int k = 0; k < 4; k++) begin
            drv(0, 0, 1'b1, 1'b0, 32'h50, 32'h0);
            drv(0, 1, 1'b1, 1'b0, 32'h40 + 32'(4 * k), 32'h0);
            exp_s(0, 1'b0, 32'h40 + 32'(4 * k), 32'h0);
            exp_r(0, 1'b1, 32'h40 + 32'(4 * k), 1);
            mid();
            chk("prio_m0_wait", {31'b0, mwait[0][0]}, 32'h1);
            chk("prio_m1_wait", {31'b0, mwait[0][1]}, 32'h0);
            tick();
        end
        drv(0, 1, 1'b0, 1'b0, 32'h0, 32'h0);
        exp_s(0, 1'b0, 32'h50, 32'h0);
        exp_r(0, 1'b0, 32'h50, 1);
        mid();
        chk("prio_m0_granted", {31'b0, mwait[0][0]}, 32'h0);
        tick();
        idle(0);

        // u1: round-robin contention for 6 cycles, first grant to m1.
        for (int k = 0; k < 6; k++) begin
            g  = gs[k];
            ga = (g == 1) ? a1s[k] : a0s[k];
            drv(1, 0, 1'b1, 1'b0, a0s[k], 32'h0);
            drv(1, 1, 1'b1, 1'b0, a1s[k], 32'h0);
            exp_s(1, 1'b0, ga, 32'h0);
            exp_r(1, g[0], ga, 3);
            mid();
            chk("rr_winner_wait", {31'b0, mwait[1][g]}, 32'h0);
            chk("rr_loser_wait", {31'b0, mwait[1][1-g]}, 32'h1);
            tick();
        end
        idle(1);
        repeat (4) tick();

        // u1: interleaved reads m0@0x10, m1@0x20, m0@0x30.
        drv(1, 0, 1'b1, 1'b0, 32'h10, 32'h0);
        exp_s(1, 1'b0, 32'h10, 32'h0);
        exp_r(1, 1'b0, 32'h10, 3);
        tick();
        drv(1, 0, 1'b0, 1'b0, 32'h0, 32'h0);
        drv(1, 1, 1'b1, 1'b0, 32'h20, 32'h0);
        exp_s(1, 1'b0, 32'h20, 32'h0);
        exp_r(1, 1'b1, 32'h20, 3);
        tick();
        drv(1, 1, 1'b0, 1'b0, 32'h0, 32'h0);
        drv(1, 0, 1'b1, 1'b0, 32'h30, 32'h0);
        exp_s(1, 1'b0, 32'h30, 32'h0);
        exp_r(1, 1'b0, 32'h30, 3);
        tick();
        idle(1);
        repeat (5) tick();

        // u1: two reads in flight (m0 then m1, so last grant is m1), then reset.
        drv(1, 0, 1'b1, 1'b0, 32'h60, 32'h0);
        exp_s(1, 1'b0, 32'h60, 32'h0);
        tick();
        drv(1, 0, 1'b0, 1'b0, 32'h0, 32'h0);
        drv(1, 1, 1'b1, 1'b0, 32'h64, 32'h0);
        exp_s(1, 1'b0, 32'h64, 32'h0);
        tick();
        idle(1);
        rst_n[1] = 1'b0;
        mid();
        chk("rst_mid_s_read", {31'b0, srd[1]}, 32'h0);
        tick();
        rst_n[1] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            mid();
            chk("rst_no_rdv0", {31'b0, mrdv[1][0]}, 32'h0);
            chk("rst_no_rdv1", {31'b0, mrdv[1][1]}, 32'h0);
            tick();
        end
        drv(1, 0, 1'b1, 1'b0, 32'h70, 32'h0);
        drv(1, 1, 1'b1, 1'b0, 32'h74, 32'h0);
        exp_s(1, 1'b0, 32'h74, 32'h0);
        exp_r(1, 1'b1, 32'h74, 3);
        mid();
        chk("post_rst_m1_first", sadr[1], 32'h74);
        chk("post_rst_m0_wait", {31'b0, mwait[1][0]}, 32'h1);
        tick();
        drv(1, 1, 1'b0, 1'b0, 32'h0, 32'h0);
        exp_s(1, 1'b0, 32'h70, 32'h0);
        exp_r(1, 1'b0, 32'h70, 3);
        tick();
        idle(1);

        // Drain outstanding responses within a bounded window.
        for (int k = 0; k < 20; k++) begin
            if (rq_size(0) == 0 && rq_size(1) == 0 && sq_size(0) == 0 && sq_size(1) == 0) break;
            tick();
        end
        tick();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("u%0d_rsp_left", i), 32'(rq_size(i)), 32'h0);
            chk($sformatf("u%0d_slave_left", i), 32'(sq_size(i)), 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
